// File: rtl/pad_poll_scheduler_if.sv
// -----------------------------------------------------------------------------
// pad_poll_scheduler_if
// Bundles the poll request, pad-facing lines and snapshot handshake of the
// controller-port poll scheduler.
//   poll_req      : single-cycle poll request (frame timing -> scheduler)
//   mode1/mode2   : per-port pad type, 0 = NES (8 bits), 1 = SNES (16 bits)
//   data1/data2   : serial pad data, active low, already synchronised
//   ack           : consumer accepts the current snapshot
//   strobe_latch  : latch line to both pads
//   shift_clock   : shift clock to both pads, idles high
//   busy          : poll sequence in progress
//   buttons1/2    : captured buttons, active high
//   valid         : snapshot available
//   overrun       : an unacknowledged snapshot was overwritten
// master = requester / pads / consumer side, slave = scheduler.
// -----------------------------------------------------------------------------
interface pad_poll_scheduler_if;
    logic        poll_req;
    logic        mode1;
    logic        mode2;
    logic        data1;
    logic        data2;
    logic        ack;
    logic        strobe_latch;
    logic        shift_clock;
    logic        busy;
    logic [15:0] buttons1;
    logic [15:0] buttons2;
    logic        valid;
    logic        overrun;

    modport master (
        output poll_req, mode1, mode2, data1, data2, ack,
        input  strobe_latch, shift_clock, busy, buttons1, buttons2, valid, overrun
    );

    modport slave (
        input  poll_req, mode1, mode2, data1, data2, ack,
        output strobe_latch, shift_clock, busy, buttons1, buttons2, valid, overrun
    );
endinterface

// File: rtl/pad_poll_scheduler.sv
// -----------------------------------------------------------------------------
// pad_poll_scheduler
// Runs the shared latch/shift sequence for both controller ports once per
// poll request and publishes a button word per port through valid/ack.
// Ports:
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : pad_poll_scheduler_if.slave (request, pad lines, snapshot)
// Parameters:
//   LATCH_CYCLES : cycles the latch line is held high per poll (>=1)
//   HALF_CYCLES  : cycles per shift-clock half period and post-latch settle (>=1)
// -----------------------------------------------------------------------------

// Per-port shadow register. Collects sampled bits for one pad and presents
// the word as it will look after the current sample, with the NES upper
// byte forced to zero.
module pad_poll_port (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_smp,
    input  logic [3:0]  i_bit,
    input  logic        i_data_n,
    input  logic        i_nes,
    output logic [15:0] o_word_nxt
);
    logic [15:0] r_shadow;
    logic [15:0] w_shadow_nxt;

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_smp) w_shadow_nxt[i_bit] = ~i_data_n;
    end

    assign o_word_nxt = i_nes ? {8'h00, w_shadow_nxt[7:0]} : w_shadow_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_shadow <= '0;
        else if (i_clr) r_shadow <= '0;
        else if (i_smp) r_shadow <= w_shadow_nxt;
    end
endmodule

module pad_poll_scheduler #(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    pad_poll_scheduler_if.slave bus
);
    localparam int NUM_PORTS = 2;
    localparam int MAXC      = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW        = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LAST_L = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] LAST_H = CW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_SHIFT_LO, S_SHIFT_HI, S_DONE
    } state_t;

    state_t                       r_state;
    logic [CW-1:0]                r_cnt;
    logic [3:0]                   r_bit;
    logic [NUM_PORTS-1:0]         r_mode;
    logic                         r_pending;
    logic                         r_strobe;
    logic                         r_shclk;
    logic                         r_busy;
    logic                         r_valid;
    logic                         r_overrun;
    logic [NUM_PORTS-1:0][15:0]   r_buttons;

    logic                         w_half_end;
    logic                         w_smp;
    logic                         w_n16;
    logic                         w_last_bit;
    logic                         w_start;
    logic [NUM_PORTS-1:0]         w_mode_in;
    logic [NUM_PORTS-1:0]         w_data_n;
    logic [NUM_PORTS-1:0][15:0]   w_word_nxt;

    assign w_mode_in  = {bus.mode2, bus.mode1};
    assign w_data_n   = {bus.data2, bus.data1};
    assign w_half_end = (r_cnt == LAST_H);
    // Bit 0 is taken at the end of SETTLE, later bits at the end of SHIFT_HI.
    assign w_smp      = w_half_end && ((r_state == S_SETTLE) || (r_state == S_SHIFT_HI));
    assign w_n16      = |r_mode;
    assign w_last_bit = (r_bit == (w_n16 ? 4'd15 : 4'd7));
    // A sequence starts from IDLE on a request, or straight out of DONE when
    // a request is queued or arrives during DONE itself.
    assign w_start    = ((r_state == S_IDLE) && bus.poll_req) ||
                        ((r_state == S_DONE) && (r_pending || bus.poll_req));

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
            pad_poll_port u_port (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_clr      (w_start),
                .i_smp      (w_smp),
                .i_bit      (r_bit),
                .i_data_n   (w_data_n[gp]),
                .i_nes      (~r_mode[gp]),
                .o_word_nxt (w_word_nxt[gp])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_mode    <= '0;
            r_pending <= 1'b0;
            r_strobe  <= 1'b0;
            r_shclk   <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_buttons <= '0;
        end else begin
            if (bus.ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            // Requests while busy collapse into a single queued poll.
            if (bus.poll_req && r_busy) r_pending <= 1'b1;

            if (w_start) begin
                r_state   <= S_LATCH;
                r_cnt     <= '0;
                r_bit     <= '0;
                r_mode    <= w_mode_in;
                r_pending <= 1'b0;
                r_strobe  <= 1'b1;
                r_shclk   <= 1'b1;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_LATCH: begin
                        if (r_cnt == LAST_L) begin
                            r_cnt    <= '0;
                            r_strobe <= 1'b0;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SETTLE: begin
                        if (w_half_end) begin
                            r_cnt   <= '0;
                            r_bit   <= 4'd1;
                            r_shclk <= 1'b0;
                            r_state <= S_SHIFT_LO;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SHIFT_LO: begin
                        if (w_half_end) begin
                            r_cnt   <= '0;
                            r_shclk <= 1'b1;
                            r_state <= S_SHIFT_HI;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SHIFT_HI: begin
                        if (w_half_end) begin
                            r_cnt <= '0;
                            if (w_last_bit) begin
                                // The snapshot is published on the edge that
                                // enters DONE, so Valid/Buttons are visible
                                // during DONE. An Ack sampled on this same edge
                                // targets the old snapshot: the new one stays
                                // valid and no overrun is flagged.
                                r_buttons <= w_word_nxt;
                                r_valid   <= 1'b1;
                                r_overrun <= r_valid && !bus.ack;
                                r_state   <= S_DONE;
                            end else begin
                                r_bit   <= r_bit + 4'd1;
                                r_shclk <= 1'b0;
                                r_state <= S_SHIFT_LO;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        // No queued request here (w_start handles that case).
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.strobe_latch = r_strobe;
    assign bus.shift_clock  = r_shclk;
    assign bus.busy         = r_busy;
    assign bus.buttons1     = r_buttons[0];
    assign bus.buttons2     = r_buttons[1];
    assign bus.valid        = r_valid;
    assign bus.overrun      = r_overrun;
endmodule
